// File: rtl/hazard_ctrl.sv
// hazard_ctrl - pipeline hazard / stall controller for the 5-stage RV32I core
//
// Resolves hazards that forwarding cannot cover:
// - load-use;
// - ID-stage branch/JALR operands produced in EX;
// - ID-stage branch/JALR operands produced by a load in EX or ME.
// It also freezes the pipe while either SRAM is waiting, and flushes IF/ID
// on a taken branch or jump that is redirected in ID.
//
// Ports
//   clk, rst                      core clock, synchronous active-high reset
//   rs1/rs2_addr_ID_i, use_rs*    source registers of the ID instruction
//   cmp_ID_i                      ID instruction is a branch/JALR
//   RegWrite/MemRead/rd_addr_EX_i EX instruction destination information
//   MemRead/rd_addr_ME_i          ME load destination
//   redirect_ID_i                 taken branch/JAL/JALR in ID
//   im_wait_i, dm_wait_i          SRAM not ready
//   PCWrite_o, IFID_Write_o       fetch-side enables
//   IFID_Flush_o, IDEX_Flush_o    flush controls
//   Freeze_o                      hold the ID/EX, EX/ME and ME/WB registers
//
// Optional build macro HAZARD_PERF_CNT_EN adds saturating counters:
//   stall_cnt_o, freeze_cnt_o and flush_cnt_o.
module hazard_ctrl #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] rs1_addr_ID_i,
  input  logic [REG_AW-1:0] rs2_addr_ID_i,
  input  logic              use_rs1_ID_i,
  input  logic              use_rs2_ID_i,
  input  logic              cmp_ID_i,
  input  logic              RegWrite_EX_i,
  input  logic              MemRead_EX_i,
  input  logic [REG_AW-1:0] rd_addr_EX_i,
  input  logic              MemRead_ME_i,
  input  logic [REG_AW-1:0] rd_addr_ME_i,
  input  logic              redirect_ID_i,
  input  logic              im_wait_i,
  input  logic              dm_wait_i,
  output logic              PCWrite_o,
  output logic              IFID_Write_o,
  output logic              IFID_Flush_o,
  output logic              IDEX_Flush_o,
  output logic              Freeze_o
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]  stall_cnt_o,
  output logic [CNT_W-1:0]  freeze_cnt_o,
  output logic [CNT_W-1:0]  flush_cnt_o
`endif
);

  typedef enum logic [1:0] {RUN, LDBR, FROZEN} state_t;

  state_t state_reg, state_next, eff_state;
  logic   resume_ldbr_reg, resume_ldbr_next;
  logic   pend_flush_reg, pend_flush_next;

  logic any_wait;
  logic dep_ex, dep_me;
  logic lu, br_alu, br_ld2, br_ld1, hazard;
  logic ldbr_ctx;
  logic stall_evt, freeze_evt, flush_evt;

  // A register number of x0 never creates a dependence.
  function automatic logic hit(input logic use_rs, input logic [REG_AW-1:0] rs,
                               input logic [REG_AW-1:0] rd);
    return use_rs && (rs != '0) && (rs == rd);
  endfunction

  assign any_wait = im_wait_i | dm_wait_i;
  assign dep_ex   = RegWrite_EX_i && (hit(use_rs1_ID_i, rs1_addr_ID_i, rd_addr_EX_i) ||
                                      hit(use_rs2_ID_i, rs2_addr_ID_i, rd_addr_EX_i));
  assign dep_me   = MemRead_ME_i  && (hit(use_rs1_ID_i, rs1_addr_ID_i, rd_addr_ME_i) ||
                                      hit(use_rs2_ID_i, rs2_addr_ID_i, rd_addr_ME_i));

  assign lu     = MemRead_EX_i && dep_ex && !cmp_ID_i;
  assign br_alu = cmp_ID_i && dep_ex && !MemRead_EX_i;
  assign br_ld2 = cmp_ID_i && dep_ex && MemRead_EX_i;
  // Write-first register file: the load's WB cycle is already safe, so one stall.
  assign br_ld1 = cmp_ID_i && dep_me;
  assign hazard = lu | br_alu | br_ld2 | br_ld1;

  // The cycle in which the waits drop is evaluated as the resumed state, so no
  // dead cycle is spent leaving FROZEN.
  always_comb begin
    eff_state = state_reg;
    if (state_reg == FROZEN && !any_wait)
      eff_state = resume_ldbr_reg ? LDBR : RUN;
  end

  // A pending forced stall means that the branch in ID is still waiting on a load.
  assign ldbr_ctx = (eff_state == LDBR) || (eff_state == FROZEN && resume_ldbr_reg);

  always_comb begin
    PCWrite_o        = 1'b1;
    IFID_Write_o     = 1'b1;
    IFID_Flush_o     = 1'b0;
    IDEX_Flush_o     = 1'b0;
    Freeze_o         = 1'b0;
    state_next       = state_reg;
    resume_ldbr_next = resume_ldbr_reg;
    pend_flush_next  = pend_flush_reg;
    stall_evt        = 1'b0;
    freeze_evt       = 1'b0;

    if (any_wait) begin
      Freeze_o     = 1'b1;
      PCWrite_o    = 1'b0;
      IFID_Write_o = 1'b0;
      freeze_evt   = 1'b1;
      state_next   = FROZEN;
      if (eff_state == LDBR)
        resume_ldbr_next = 1'b1;
      else if (eff_state == RUN)
        resume_ldbr_next = 1'b0;
      // Remember the redirect so it is not lost behind the freeze.
      if (redirect_ID_i && !hazard && !ldbr_ctx)
        pend_flush_next = 1'b1;
    end else if (eff_state == LDBR) begin
      stall_evt        = 1'b1;
      state_next       = RUN;
      resume_ldbr_next = 1'b0;
    end else begin
      state_next       = RUN;
      resume_ldbr_next = 1'b0;
      pend_flush_next  = 1'b0;
      if (br_ld2) begin
        stall_evt  = 1'b1;
        state_next = LDBR;
      end else if (hazard) begin
        stall_evt = 1'b1;
      end else if (redirect_ID_i || pend_flush_reg) begin
        IFID_Flush_o = 1'b1;
      end
    end

    if (stall_evt) begin
      PCWrite_o    = 1'b0;
      IFID_Write_o = 1'b0;
      IDEX_Flush_o = 1'b1;
    end

    flush_evt = IFID_Flush_o;

    if (rst) begin
      PCWrite_o    = 1'b0;
      IFID_Write_o = 1'b0;
      IFID_Flush_o = 1'b1;
      IDEX_Flush_o = 1'b1;
      Freeze_o     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= RUN;
      resume_ldbr_reg <= 1'b0;
      pend_flush_reg  <= 1'b0;
    end else begin
      state_reg       <= state_next;
      resume_ldbr_reg <= resume_ldbr_next;
      pend_flush_reg  <= pend_flush_next;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] cnt_reg [3];
  logic [2:0]       cnt_evt;

  assign cnt_evt = {flush_evt, freeze_evt, stall_evt};

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_cnt
      always_ff @(posedge clk) begin
        if (rst)
          cnt_reg[gi] <= '0;
        else if (cnt_evt[gi] && !(&cnt_reg[gi]))
          cnt_reg[gi] <= cnt_reg[gi] + 1'b1;
      end
    end
  endgenerate

  assign stall_cnt_o  = cnt_reg[0];
  assign freeze_cnt_o = cnt_reg[1];
  assign flush_cnt_o  = cnt_reg[2];
`else
  // The event flags feed only the optional counters.
  logic unused_evt;
  assign unused_evt = stall_evt ^ freeze_evt ^ flush_evt;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl - scoreboard bench for hazard_ctrl.
//
// The stimulus process first drives each cycle's inputs. A cycle-level
// reference model then derives the expected outputs and queues them. A
// separate monitor pops each queued entry on the falling edge and compares it
// with the DUT outputs.
//
// The model does not use a state machine. It tracks two items: the number of
// forced stalls still owed, and whether a flush is still pending.
module tb_hazard_ctrl;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] rs1_addr_ID_i, rs2_addr_ID_i, rd_addr_EX_i, rd_addr_ME_i;
  logic          use_rs1_ID_i, use_rs2_ID_i, cmp_ID_i;
  logic          RegWrite_EX_i, MemRead_EX_i, MemRead_ME_i;
  logic          redirect_ID_i, im_wait_i, dm_wait_i;
  logic          PCWrite_o, IFID_Write_o, IFID_Flush_o, IDEX_Flush_o, Freeze_o;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0]   stall_cnt_o, freeze_cnt_o, flush_cnt_o;
`endif

  always #5 clk = ~clk;

  hazard_ctrl #(.REG_AW(AW), .CNT_W(32)) dut (
    .clk(clk), .rst(rst),
    .rs1_addr_ID_i(rs1_addr_ID_i), .rs2_addr_ID_i(rs2_addr_ID_i),
    .use_rs1_ID_i(use_rs1_ID_i), .use_rs2_ID_i(use_rs2_ID_i), .cmp_ID_i(cmp_ID_i),
    .RegWrite_EX_i(RegWrite_EX_i), .MemRead_EX_i(MemRead_EX_i), .rd_addr_EX_i(rd_addr_EX_i),
    .MemRead_ME_i(MemRead_ME_i), .rd_addr_ME_i(rd_addr_ME_i),
    .redirect_ID_i(redirect_ID_i), .im_wait_i(im_wait_i), .dm_wait_i(dm_wait_i),
    .PCWrite_o(PCWrite_o), .IFID_Write_o(IFID_Write_o), .IFID_Flush_o(IFID_Flush_o),
    .IDEX_Flush_o(IDEX_Flush_o), .Freeze_o(Freeze_o)
`ifdef HAZARD_PERF_CNT_EN
    , .stall_cnt_o(stall_cnt_o), .freeze_cnt_o(freeze_cnt_o), .flush_cnt_o(flush_cnt_o)
`endif
  );

  // Expected vector layout: {PCWrite, IFID_Write, IFID_Flush, IDEX_Flush, Freeze}
  localparam logic [4:0] E_RESET  = 5'b00110;
  localparam logic [4:0] E_FREEZE = 5'b00001;
  localparam logic [4:0] E_STALL  = 5'b00010;
  localparam logic [4:0] E_FLUSH  = 5'b11100;
  localparam logic [4:0] E_NORMAL = 5'b11000;

  logic [4:0] exp_q[$];
  string      lbl_q[$];
  int         n_checks = 0;
  int         n_fail   = 0;

  // Reference model state
  int owed_stalls = 0;
  bit pend        = 1'b0;

  function automatic bit reads(input bit use_rs, input logic [AW-1:0] rs, input logic [AW-1:0] rd);
    return use_rs && rs != 0 && rs == rd;
  endfunction

  task automatic clear_inputs();
    rst = 1'b0;
    rs1_addr_ID_i = '0; rs2_addr_ID_i = '0; use_rs1_ID_i = 1'b0; use_rs2_ID_i = 1'b0;
    cmp_ID_i = 1'b0; RegWrite_EX_i = 1'b0; MemRead_EX_i = 1'b0; rd_addr_EX_i = '0;
    MemRead_ME_i = 1'b0; rd_addr_ME_i = '0; redirect_ID_i = 1'b0;
    im_wait_i = 1'b0; dm_wait_i = 1'b0;
  endtask

  // Derive the expected outputs from the inputs currently driven.
  // Then queue them and advance by one clock cycle.
  task automatic step(input string lbl);
    bit dex, dme, ld2, one;
    logic [4:0] e;
    dex = RegWrite_EX_i && (reads(use_rs1_ID_i, rs1_addr_ID_i, rd_addr_EX_i) ||
                            reads(use_rs2_ID_i, rs2_addr_ID_i, rd_addr_EX_i));
    dme = MemRead_ME_i && (reads(use_rs1_ID_i, rs1_addr_ID_i, rd_addr_ME_i) ||
                           reads(use_rs2_ID_i, rs2_addr_ID_i, rd_addr_ME_i));
    ld2 = cmp_ID_i && dex && MemRead_EX_i;
    one = (MemRead_EX_i && dex && !cmp_ID_i) || (cmp_ID_i && dex && !MemRead_EX_i) ||
          (cmp_ID_i && dme);
    if (rst) begin
      e = E_RESET; owed_stalls = 0; pend = 1'b0;
    end else if (im_wait_i || dm_wait_i) begin
      e = E_FREEZE;
      if (owed_stalls == 0 && redirect_ID_i && !ld2 && !one) pend = 1'b1;
    end else if (owed_stalls > 0) begin
      e = E_STALL; owed_stalls--;
    end else begin
      if (ld2) begin e = E_STALL; owed_stalls = 1; end
      else if (one) e = E_STALL;
      else if (redirect_ID_i || pend) e = E_FLUSH;
      else e = E_NORMAL;
      pend = 1'b0;
    end
    exp_q.push_back(e);
    lbl_q.push_back(lbl);
    @(posedge clk); #1;
  endtask

  // Monitor: the outputs are valid in every cycle, so each queued entry is compared.
  always @(negedge clk) begin
    logic [4:0] got, e;
    string l;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      l = lbl_q.pop_front();
      got = {PCWrite_o, IFID_Write_o, IFID_Flush_o, IDEX_Flush_o, Freeze_o};
      n_checks++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL %s: outputs {pcw,ifidw,ifidf,idexf,frz} got %b expected %b", l, got, e);
      end else begin
        $display("check %0d %s: %b ok", n_checks, l, got);
      end
    end
  end

  initial begin
    clear_inputs();
    rst = 1'b1;
    @(posedge clk); #1;
    step("reset0");
    step("reset1");
    rst = 1'b0;
    step("idle");

    // Load-use: load x5 in EX and ADD x5 in ID.
    RegWrite_EX_i = 1; MemRead_EX_i = 1; rd_addr_EX_i = 5; use_rs1_ID_i = 1; rs1_addr_ID_i = 5;
    step("lu_stall");
    RegWrite_EX_i = 0; MemRead_EX_i = 0; rd_addr_EX_i = 0;
    step("lu_release");

    // Load x7 in EX and BEQ x7,x0 in ID: two stalls, then the redirect flush.
    clear_inputs();
    cmp_ID_i = 1; use_rs1_ID_i = 1; use_rs2_ID_i = 1; rs1_addr_ID_i = 7;
    RegWrite_EX_i = 1; MemRead_EX_i = 1; rd_addr_EX_i = 7;
    step("brld_stall1");
    RegWrite_EX_i = 0; MemRead_EX_i = 0; rd_addr_EX_i = 0; MemRead_ME_i = 1; rd_addr_ME_i = 7;
    step("brld_stall2");
    MemRead_ME_i = 0; rd_addr_ME_i = 0; redirect_ID_i = 1;
    step("brld_redirect");
    clear_inputs();
    step("brld_after");

    // ADD x3 in EX and JALR x3 in ID: one stall. With rd=x0, no stall.
    cmp_ID_i = 1; use_rs1_ID_i = 1; rs1_addr_ID_i = 3; RegWrite_EX_i = 1; rd_addr_EX_i = 3;
    step("bralu_stall");
    rd_addr_EX_i = 0; rs1_addr_ID_i = 0;
    step("bralu_x0");
    clear_inputs();

    // dm_wait is held high for three cycles while in LDBR.
    cmp_ID_i = 1; use_rs1_ID_i = 1; rs1_addr_ID_i = 9;
    RegWrite_EX_i = 1; MemRead_EX_i = 1; rd_addr_EX_i = 9;
    step("ldbr_enter");
    RegWrite_EX_i = 0; MemRead_EX_i = 0; dm_wait_i = 1;
    for (int i = 0; i < 3; i++) step("ldbr_freeze");
    dm_wait_i = 0;
    step("ldbr_resume_stall");
    clear_inputs();
    step("ldbr_run");

    // A redirect while im_wait is high is deferred until the wait drops.
    redirect_ID_i = 1; im_wait_i = 1;
    step("pend_frozen0");
    step("pend_frozen1");
    redirect_ID_i = 0; im_wait_i = 0;
    step("pend_flush");
    step("pend_clear");

    // Reset is asserted in the middle of an LDBR stall.
    cmp_ID_i = 1; use_rs2_ID_i = 1; rs2_addr_ID_i = 4;
    RegWrite_EX_i = 1; MemRead_EX_i = 1; rd_addr_EX_i = 4;
    step("rst_ldbr_enter");
    clear_inputs(); rst = 1;
    step("rst_in_ldbr");
    rst = 0;
    step("rst_after");

    // Randomized traffic: small register numbers make dependences frequent.
    for (int i = 0; i < 500; i++) begin
      rst           = ($urandom_range(0, 59) == 0);
      rs1_addr_ID_i = AW'($urandom_range(0, 3));
      rs2_addr_ID_i = AW'($urandom_range(0, 3));
      rd_addr_EX_i  = AW'($urandom_range(0, 3));
      rd_addr_ME_i  = AW'($urandom_range(0, 3));
      use_rs1_ID_i  = $urandom_range(0, 1) == 1;
      use_rs2_ID_i  = $urandom_range(0, 1) == 1;
      cmp_ID_i      = $urandom_range(0, 1) == 1;
      RegWrite_EX_i = $urandom_range(0, 3) != 0;
      MemRead_EX_i  = $urandom_range(0, 2) == 0;
      MemRead_ME_i  = $urandom_range(0, 2) == 0;
      redirect_ID_i = $urandom_range(0, 2) == 0;
      im_wait_i     = $urandom_range(0, 7) == 0;
      dm_wait_i     = $urandom_range(0, 7) == 0;
      step("random");
    end
    clear_inputs();
    step("final");

    // Drain the scoreboard within a bounded number of cycles.
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d entries left, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline hazard and stall controller for the 5-stage RV32I core with one-cycle-delay instruction and data SRAMs.
- Sits beside the forwarding unit and covers the cases forwarding cannot resolve: load-use, and ID-stage branch/JALR operands produced in EX or by a load.
- Also handles SRAM wait freezes and taken-branch/jump flushes.
- Drives PC write-enable, IF/ID write/flush, ID/EX bubble insertion and the whole-pipe freeze.

Parameters:
- REG_AW, 5, register address width.
- CNT_W, 32, width of the performance counters (optional feature only).

Ports:
- clk  input  1  core clock.
- rst  input  1  synchronous active-high reset.
- rs1_addr_ID_i  input  REG_AW  rs1 of the instruction in ID.
- rs2_addr_ID_i  input  REG_AW  rs2 of the instruction in ID.
- use_rs1_ID_i  input  1  ID instruction reads rs1.
- use_rs2_ID_i  input  1  ID instruction reads rs2.
- cmp_ID_i  input  1  ID instruction is a branch or JALR (operands consumed in ID).
- RegWrite_EX_i  input  1  EX instruction writes rd.
- MemRead_EX_i  input  1  EX instruction is a load.
- rd_addr_EX_i  input  REG_AW  EX destination.
- MemRead_ME_i  input  1  ME instruction is a load.
- rd_addr_ME_i  input  REG_AW  ME destination.
- redirect_ID_i  input  1  taken branch, JAL or JALR resolved in ID.
- im_wait_i  input  1  instruction SRAM not ready.
- dm_wait_i  input  1  data SRAM not ready.
- PCWrite_o  output  1  PC update enable.
- IFID_Write_o  output  1  IF/ID register load enable.
- IFID_Flush_o  output  1  IF/ID register cleared to NOP.
- IDEX_Flush_o  output  1  bubble inserted into ID/EX.
- Freeze_o  output  1  hold ID/EX, EX/ME and ME/WB.

Behaviour:
- Matching uses only addresses != 0, gated by use_rsX_ID_i.
- depEX = RegWrite_EX_i && rd_EX matches a used rs.
- depME = MemRead_ME_i && rd_ME matches a used rs.
- Hazard classes, evaluated combinationally in RUN:
  - LU: MemRead_EX_i && depEX && !cmp_ID_i. 1 stall.
  - BR_ALU: cmp_ID_i && depEX && !MemRead_EX_i. 1 stall.
  - BR_LD2: cmp_ID_i && depEX && MemRead_EX_i. 2 stalls.
  - BR_LD1: cmp_ID_i && depME. 1 stall. The register file is write-first, so data read in ID during the load's WB is valid.
- Stall outputs: PCWrite_o=0, IFID_Write_o=0, IDEX_Flush_o=1, IFID_Flush_o=0, Freeze_o=0.
- FSM states: RUN, LDBR, FROZEN.
  - RUN:
    - If im_wait_i|dm_wait_i, apply freeze outputs and go to FROZEN.
    - Else if BR_LD2, stall and go to LDBR.
    - Else if LU/BR_ALU/BR_LD1, stall and stay in RUN.
    - Else if redirect_ID_i, IFID_Flush_o=1 with PC/IF-ID writes enabled.
    - Else all enables=1, flushes=0.
  - LDBR: forced second stall regardless of hazard inputs, then go to RUN. If a wait arrives in LDBR, go to FROZEN with resume_ldbr=1.
  - FROZEN:
    - While any wait is high: Freeze_o=1, PCWrite_o=0, IFID_Write_o=0, both flushes 0.
    - When all waits are low, go to LDBR if resume_ldbr, else RUN. Clear resume_ldbr.
- Freeze outputs: Freeze_o=1, PCWrite_o=0, IFID_Write_o=0, flushes 0.
- Priority: wait freeze > LDBR forced stall > data hazard stall > redirect flush.
- A redirect coinciding with a stall is ignored that cycle. It recurs once the branch is re-evaluated after the stall.
- pend_flush register:
  - Set when redirect_ID_i=1 and the cycle is frozen, with no hazard present.
  - Its IFID_Flush_o=1 is issued on the first unfrozen RUN cycle, then it clears.
- Reset (rst=1): state=RUN, resume_ldbr=0, pend_flush=0.
- Outputs while rst=1: PCWrite_o=0, IFID_Write_o=0, IFID_Flush_o=1, IDEX_Flush_o=1, Freeze_o=0.
- First cycle after reset release: normal RUN evaluation.
- Latency: all outputs are combinational from the current state and inputs. The state updates on the clk edge.

Optional Feature:
- Macro: HAZARD_PERF_CNT_EN.
- When defined, three CNT_W-bit counters are added: stall_cnt_o, freeze_cnt_o, flush_cnt_o.
  - Incremented each cycle the respective stall, freeze or IFID flush condition is asserted.
  - Saturate at all-ones.
  - Cleared by rst.
- When undefined, the ports and logic are absent. Core behaviour is identical in both cases.

Test Plan:
- Load x5 in EX, ADD using x5 in ID -> exactly 1 cycle with PCWrite_o=0, IDEX_Flush_o=1; next cycle all enables 1.
- Load x7 in EX, BEQ x7,x0 in ID -> 2 consecutive stall cycles (state RUN->LDBR->RUN); then redirect_ID_i=1 -> IFID_Flush_o=1 one cycle.
- ADD writing x3 in EX, JALR x3 in ID -> 1 stall; rd=x0 with the same pattern -> no stall.
- dm_wait_i high 3 cycles during LDBR -> Freeze_o=1 for 3 cycles, then 1 LDBR stall cycle, then RUN.
- redirect_ID_i=1 while im_wait_i=1 -> no flush while frozen; IFID_Flush_o=1 on the first cycle after im_wait_i falls.
- rst asserted mid-stall in LDBR -> next cycle reset outputs (IFID_Flush_o=1, IDEX_Flush_o=1, PCWrite_o=0); after release, state RUN with no residual stall.
